// File: rtl/ps2_uart_pkg.sv
// Shared types, constants and helpers for the PS2 UART router.
package ps2_uart_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        PEND,
        SWITCH
    } state_t;

    // UART lines idle high; synchronisers leave reset showing "no traffic".
    localparam logic SYNC_RST_LVL = 1'b1;

    // max(1, clog2(n)): CH_W, and wide enough for any counter that holds n-1.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_uart_debounce.sv
// Synchroniser, debouncer and press-pulse generator for one active-low button.
module ps2_uart_debounce
    import ps2_uart_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic press
);

    localparam int               CNT_W   = ch_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             synced;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= SYNC_RST_LVL;
            synced <= SYNC_RST_LVL;
        end else begin
            meta   <= din;
            synced <= meta;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= SYNC_RST_LVL;
            level_d <= SYNC_RST_LVL;
            cnt     <= '0;
        end else begin
            level_d <= level;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level_d & ~level;

endmodule

// File: rtl/ps2_uart_mux.sv
// Button-selected UART router between the FT2232 channel B and up to eight PS2 target UARTs.
// Optional activity LED stretcher enabled with `define PS2_UART_ACT_LED_EN.
module ps2_uart_mux
    import ps2_uart_pkg::*;
#(
    parameter int  CHANNELS        = 2,
    parameter int  DEBOUNCE_CYCLES = 65536,
    parameter int  IDLE_CYCLES     = 1024,
    parameter int  DEFAULT_CH      = 0,
    parameter int  ACT_STRETCH     = 2097152,
    localparam int CH_W            = ch_width(CHANNELS)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                FT_TXD,
    output logic                FT_RXD,
    input  logic [CHANNELS-1:0] TGT_TXD,
    output logic [CHANNELS-1:0] TGT_RXD,
    output logic [CHANNELS-1:0] TGT_RXD_OE,
    input  logic                SEL_BTN_n,
    input  logic                TESTMODE_BTN_n,
    output logic                TESTMODE_OE,
    output logic [CH_W-1:0]     CH_LED,
    output logic                ACT_LED
);

    localparam int                SYNC_W   = CHANNELS + 2;
    localparam int                IDLE_W   = ch_width(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(CHANNELS - 1);

    if (CHANNELS < 2 || CHANNELS > 8 || DEFAULT_CH < 0 || DEFAULT_CH >= CHANNELS ||
        DEBOUNCE_CYCLES < 1 || IDLE_CYCLES < 1 || ACT_STRETCH < 1) begin : g_bad_params
        $error("ps2_uart_mux: parameter out of range");
    end

    state_t                state;
    state_t                state_next;
    logic [SYNC_W-1:0]     sync_meta;
    logic [SYNC_W-1:0]     sync_q;
    logic [CHANNELS-1:0]   tgt_sync;
    logic                  ft_sync;
    logic                  tm_sync;
    logic                  press;
    logic [CH_W-1:0]       sel;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  lines_idle;
    logic                  fwd_en;
    logic                  advance;
    logic [CHANNELS-1:0]   oe_next;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_meta <= {SYNC_W{SYNC_RST_LVL}};
            sync_q    <= {SYNC_W{SYNC_RST_LVL}};
        end else begin
            sync_meta <= {TESTMODE_BTN_n, FT_TXD, TGT_TXD};
            sync_q    <= sync_meta;
        end
    end

    assign tgt_sync    = sync_q[CHANNELS-1:0];
    assign ft_sync     = sync_q[CHANNELS];
    assign tm_sync     = sync_q[CHANNELS+1];
    assign TESTMODE_OE = ~tm_sync;
    assign lines_idle  = ft_sync & tgt_sync[sel];

    ps2_uart_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sel_debounce (
        .clk  (CLK),
        .rst_n(nRST),
        .din  (SEL_BTN_n),
        .press(press)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Presses seen outside RUN fall through unhandled, so they are dropped rather than queued.
    always_comb begin
        state_next = state;
        unique case (state)
            INIT:    state_next = RUN;
            RUN:     if (press) state_next = PEND;
            PEND:    if (idle_cnt == IDLE_MAX) state_next = SWITCH;
            SWITCH:  state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fwd_en  = 1'b0;
        advance = 1'b0;
        oe_next = '0;
        unique case (state)
            RUN, PEND: fwd_en  = 1'b1;
            SWITCH:    advance = 1'b1;
            default:   fwd_en  = 1'b0;
        endcase
        if (fwd_en) oe_next[sel] = 1'b1;
    end

    // Counts consecutive cycles with both directions idle; any low bit restarts the wait.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idle_cnt <= '0;
        end else if (state != PEND || !lines_idle) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel <= CH_W'(DEFAULT_CH);
        end else if (advance) begin
            sel <= (sel == LAST_CH) ? '0 : sel + 1'b1;
        end
    end

    // Output register: OE lags the state by one cycle, giving the single all-off gap on a switch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            FT_RXD     <= 1'b1;
            TGT_RXD    <= '1;
            TGT_RXD_OE <= '0;
            CH_LED     <= CH_W'(DEFAULT_CH);
        end else begin
            FT_RXD     <= fwd_en ? tgt_sync[sel] : 1'b1;
            TGT_RXD    <= {CHANNELS{ft_sync}};
            TGT_RXD_OE <= oe_next;
            CH_LED     <= sel;
        end
    end

`ifdef PS2_UART_ACT_LED_EN
    localparam int               ACT_W   = ch_width(ACT_STRETCH);
    localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(ACT_STRETCH - 1);

    logic [ACT_W-1:0] act_cnt;
    logic             ft_prev;
    logic             tgt_prev;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            act_cnt  <= '0;
            ft_prev  <= SYNC_RST_LVL;
            tgt_prev <= SYNC_RST_LVL;
        end else begin
            ft_prev  <= ft_sync;
            tgt_prev <= tgt_sync[sel];
            if (ft_sync != ft_prev || tgt_sync[sel] != tgt_prev) begin
                act_cnt <= ACT_MAX;
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 1'b1;
            end
        end
    end

    assign ACT_LED = (act_cnt != '0);
`else
    assign ACT_LED = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_uart_mux.sv
// Self-checking bench for ps2_uart_mux: forwarding vectors plus switch, bounce, wrap and reset sequences.
module tb_ps2_uart_mux;

    localparam int CHANNELS        = 3;
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int IDLE_CYCLES     = 8;
    localparam int DEFAULT_CH      = 0;
    localparam int ACT_STRETCH     = 4;

    logic       CLK            = 1'b0;
    logic       nRST           = 1'b0;
    logic       FT_TXD         = 1'b1;
    logic       FT_RXD;
    logic [2:0] TGT_TXD        = 3'b111;
    logic [2:0] TGT_RXD;
    logic [2:0] TGT_RXD_OE;
    logic       SEL_BTN_n      = 1'b1;
    logic       TESTMODE_BTN_n = 1'b1;
    logic       TESTMODE_OE;
    logic [1:0] CH_LED;
    logic       ACT_LED;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_multi = 0;
    int tm_bad   = 0;
    bit tm_hold  = 1'b0;

    typedef struct {
        logic       ft;
        logic [2:0] tgt;
        logic       exp_ft_rxd;
        logic [2:0] exp_tgt_rxd;
    } vec_t;

    vec_t vecs[7];

    always #5 CLK = ~CLK;

    ps2_uart_mux #(
        .CHANNELS       (CHANNELS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_CYCLES    (IDLE_CYCLES),
        .DEFAULT_CH     (DEFAULT_CH),
        .ACT_STRETCH    (ACT_STRETCH)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .FT_TXD        (FT_TXD),
        .FT_RXD        (FT_RXD),
        .TGT_TXD       (TGT_TXD),
        .TGT_RXD       (TGT_RXD),
        .TGT_RXD_OE    (TGT_RXD_OE),
        .SEL_BTN_n     (SEL_BTN_n),
        .TESTMODE_BTN_n(TESTMODE_BTN_n),
        .TESTMODE_OE   (TESTMODE_OE),
        .CH_LED        (CH_LED),
        .ACT_LED       (ACT_LED)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        nRST           = 1'b0;
        FT_TXD         = 1'b1;
        TGT_TXD        = 3'b111;
        SEL_BTN_n      = 1'b1;
        TESTMODE_BTN_n = 1'b1;
        repeat (3) tick();
        nRST = 1'b1;
    endtask

    // Runs n cycles holding the button low for the first btn_low of them and records the OE history.
    task automatic run(input int n, input int btn_low, output int sw, output int gap,
                       output int first_gap, output logic [2:0] oe_after, output logic [1:0] led_after);
        logic [2:0] last_nz;
        sw        = 0;
        gap       = 0;
        first_gap = -1;
        oe_after  = 3'b000;
        led_after = 2'b00;
        last_nz   = TGT_RXD_OE;
        for (int t = 1; t <= n; t++) begin
            SEL_BTN_n = (t <= btn_low) ? 1'b0 : 1'b1;
            tick();
            if ((TGT_RXD_OE & (TGT_RXD_OE - 3'd1)) != 3'b000) oe_multi++;
            if (tm_hold && TESTMODE_OE !== 1'b1) tm_bad++;
            if (first_gap > 0 && t == first_gap + 1) begin
                oe_after  = TGT_RXD_OE;
                led_after = CH_LED;
            end
            if (TGT_RXD_OE == 3'b000) begin
                gap++;
                if (first_gap < 0) first_gap = t;
            end else if (TGT_RXD_OE != last_nz) begin
                sw++;
                last_nz = TGT_RXD_OE;
            end
        end
        SEL_BTN_n = 1'b1;
    endtask

    initial begin
        int         sw, gap, fg, bad_fwd, bad_oe;
        logic [2:0] oa;
        logic [1:0] la;
        logic       ft_val;
        logic       ft_hist[3];

        vecs[0] = '{1'b1, 3'b111, 1'b1, 3'b111};
        vecs[1] = '{1'b0, 3'b111, 1'b1, 3'b000};
        vecs[2] = '{1'b1, 3'b110, 1'b0, 3'b111};
        vecs[3] = '{1'b0, 3'b010, 1'b0, 3'b000};
        vecs[4] = '{1'b1, 3'b101, 1'b1, 3'b111};
        vecs[5] = '{1'b0, 3'b011, 1'b1, 3'b000};
        vecs[6] = '{1'b1, 3'b111, 1'b1, 3'b111};

        // Reset values and release timing
        nRST = 1'b0;
        repeat (3) tick();
        check("rst_ft_rxd", 32'(FT_RXD), 32'd1);
        check("rst_tgt_rxd", 32'(TGT_RXD), 32'h7);
        check("rst_oe", 32'(TGT_RXD_OE), 32'h0);
        check("rst_ch_led", 32'(CH_LED), 32'd0);
        check("rst_testmode_oe", 32'(TESTMODE_OE), 32'd0);
        check("rst_act_led", 32'(ACT_LED), 32'd0);
        nRST = 1'b1;
        tick();
        check("oe_init_cycle", 32'(TGT_RXD_OE), 32'h0);
        tick();
        check("oe_first_run", 32'(TGT_RXD_OE), 32'h1);
        check("ch_led_first_run", 32'(CH_LED), 32'd0);
        check("ft_rxd_first_run", 32'(FT_RXD), 32'd1);
        TGT_TXD[0] = 1'b0;
        tick();
        tick();
        check("fwd_latency_2", 32'(FT_RXD), 32'd1);
        tick();
        check("fwd_latency_3", 32'(FT_RXD), 32'd0);
        TGT_TXD = 3'b111;
        repeat (3) tick();

        // Forwarding vectors on channel 0
        for (int i = 0; i < 7; i++) begin
            FT_TXD  = vecs[i].ft;
            TGT_TXD = vecs[i].tgt;
            repeat (3) tick();
            check($sformatf("vec%0d_ft_rxd", i), 32'(FT_RXD), 32'(vecs[i].exp_ft_rxd));
            check($sformatf("vec%0d_tgt_rxd", i), 32'(TGT_RXD), 32'(vecs[i].exp_tgt_rxd));
            check($sformatf("vec%0d_oe", i), 32'(TGT_RXD_OE), 32'h1);
        end

        // Press held 20 cycles, lines idle: one switch 0 -> 1 with a one-cycle gap
        run(60, 20, sw, gap, fg, oa, la);
        check("press_switch_count", 32'(sw), 32'd1);
        check("press_gap_cycles", 32'(gap), 32'd1);
        check("press_gap_cycle_index", 32'(fg), 32'd28);
        check("press_oe_after_gap", 32'(oa), 32'h2);
        check("press_led_after_gap", 32'(la), 32'd1);

        // Bouncy press: ten 1-cycle glitches then a 5-cycle low
        for (int i = 0; i < 10; i++) begin
            SEL_BTN_n = 1'b0;
            tick();
            SEL_BTN_n = 1'b1;
            tick();
        end
        SEL_BTN_n = 1'b0;
        repeat (5) tick();
        run(40, 0, sw, gap, fg, oa, la);
        check("bounce_switch_count", 32'(sw), 32'd0);
        check("bounce_gap_cycles", 32'(gap), 32'd0);
        check("bounce_oe", 32'(TGT_RXD_OE), 32'h2);
        check("bounce_ch_led", 32'(CH_LED), 32'd1);

        // Press while FT_TXD toggles every 4 cycles: switch deferred, channel 0 keeps forwarding
        do_reset();
        tick();
        tick();
        ft_val  = 1'b1;
        bad_fwd = 0;
        bad_oe  = 0;
        for (int k = 0; k < 3; k++) ft_hist[k] = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t % 4 == 0) ft_val = ~ft_val;
            FT_TXD     = ft_val;
            SEL_BTN_n  = (t < 20) ? 1'b0 : 1'b1;
            ft_hist[2] = ft_hist[1];
            ft_hist[1] = ft_hist[0];
            ft_hist[0] = ft_val;
            tick();
            if (TGT_RXD !== {3{ft_hist[2]}}) bad_fwd++;
            if (TGT_RXD_OE !== 3'b001 || FT_RXD !== 1'b1) bad_oe++;
        end
        check("busy_fwd_errors", 32'(bad_fwd), 32'd0);
        check("busy_oe_errors", 32'(bad_oe), 32'd0);
        FT_TXD = 1'b1;
        run(30, 0, sw, gap, fg, oa, la);
        check("busy_gap_cycle_index", 32'(fg), 32'd11);
        check("busy_switch_count", 32'(sw), 32'd1);
        check("busy_oe_after_gap", 32'(oa), 32'h2);

        // Walk 1 -> 2 -> 0 (wrap) -> 1
        run(60, 20, sw, gap, fg, oa, la);
        check("walk_to2_oe", 32'(TGT_RXD_OE), 32'h4);
        check("walk_to2_led", 32'(CH_LED), 32'd2);
        run(60, 20, sw, gap, fg, oa, la);
        check("wrap_switch_count", 32'(sw), 32'd1);
        check("wrap_oe", 32'(TGT_RXD_OE), 32'h1);
        check("wrap_led", 32'(CH_LED), 32'd0);
        run(60, 20, sw, gap, fg, oa, la);
        check("walk_to1_oe", 32'(TGT_RXD_OE), 32'h2);
        check("walk_to1_led", 32'(CH_LED), 32'd1);

        // Second press during PEND is lost, not queued
        FT_TXD = 1'b0;
        run(60, 20, sw, gap, fg, oa, la);
        check("pend_hold_switch_count", 32'(sw + gap), 32'd0);
        run(60, 20, sw, gap, fg, oa, la);
        check("pend_extra_press_switch_count", 32'(sw + gap), 32'd0);
        FT_TXD = 1'b1;
        run(40, 0, sw, gap, fg, oa, la);
        check("pend_release_switch_count", 32'(sw), 32'd1);
        check("pend_release_gap_index", 32'(fg), 32'd11);
        check("pend_release_oe", 32'(TGT_RXD_OE), 32'h4);
        check("pend_release_led", 32'(CH_LED), 32'd2);

        // Reset asserted during PEND
        FT_TXD = 1'b0;
        run(40, 20, sw, gap, fg, oa, la);
        nRST = 1'b0;
        #1;
        check("midpend_rst_oe", 32'(TGT_RXD_OE), 32'h0);
        check("midpend_rst_tgt_rxd", 32'(TGT_RXD), 32'h7);
        check("midpend_rst_ch_led", 32'(CH_LED), 32'd0);
        check("midpend_rst_ft_rxd", 32'(FT_RXD), 32'd1);
        do_reset();
        tick();
        tick();
        run(40, 0, sw, gap, fg, oa, la);
        check("after_rst_switch_count", 32'(sw + gap), 32'd0);
        check("after_rst_oe", 32'(TGT_RXD_OE), 32'h1);
        check("after_rst_led", 32'(CH_LED), 32'd0);

        // Test-mode strap across RUN, PEND and SWITCH
        TESTMODE_BTN_n = 1'b0;
        tick();
        check("testmode_1cycle", 32'(TESTMODE_OE), 32'd0);
        tick();
        check("testmode_2cycle", 32'(TESTMODE_OE), 32'd1);
        tm_hold = 1'b1;
        run(60, 20, sw, gap, fg, oa, la);
        tm_hold = 1'b0;
        check("testmode_during_switch", 32'(tm_bad), 32'd0);
        check("testmode_switch_count", 32'(sw), 32'd1);
        TESTMODE_BTN_n = 1'b1;
        tick();
        tick();
        check("testmode_release", 32'(TESTMODE_OE), 32'd0);

        check("oe_at_most_one_hot", 32'(oe_multi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
